// File: rtl/mips_pc_pkg.sv
// Shared types and constants for the MIPS program-counter sequencer.
package mips_pc_pkg;

    typedef enum logic [1:0] {
        SEQ    = 2'd0,
        DELAY  = 2'd1,
        HALTED = 2'd2
    } pc_state_t;

    localparam logic [31:0] PC_RESET_VECTOR = 32'hBFC0_0000;
    localparam logic [31:0] PC_HALT_ADDRESS = 32'h0000_0000;
    localparam logic [31:0] PC_STEP         = 32'd4;

endpackage

// File: rtl/mips_pc_sequencer.sv
// PC controller: sequential fetch, one branch delay slot, halt on HALT_ADDRESS.
// Optional misaligned-target trap enabled by MIPS_PC_ALIGN_CHECK_EN.
import mips_pc_pkg::*;

module mips_pc_sequencer #(
    parameter logic [31:0] RESET_VECTOR = PC_RESET_VECTOR,
    parameter logic [31:0] HALT_ADDRESS = PC_HALT_ADDRESS
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        clk_enable,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jump_valid,
    input  logic [31:0] jump_target,
    output logic [31:0] instr_address,
    output logic        active,
    output logic        in_delay_slot,
    output logic [31:0] link_address,
    output logic [31:0] instr_count,
`ifdef MIPS_PC_ALIGN_CHECK_EN
    output logic        addr_error,
`endif
    output pc_state_t   debug_state
);

    pc_state_t   state;
    pc_state_t   next_state;
    logic [31:0] pending;
    logic [31:0] next_pending;
    logic [31:0] next_pc;
    logic [31:0] pc_plus4;
    logic        adv;
`ifdef MIPS_PC_ALIGN_CHECK_EN
    logic        next_misaligned;
`endif

    assign adv          = clk_enable & ~stall & active;
    assign pc_plus4     = instr_address + PC_STEP;
    assign link_address = instr_address + 32'd8;
    assign debug_state  = state;

    always_comb begin
        next_pc      = instr_address;
        next_state   = state;
        next_pending = pending;
`ifdef MIPS_PC_ALIGN_CHECK_EN
        next_misaligned = 1'b0;
`endif
        case (state)
            SEQ: begin
                next_pc = pc_plus4;
                // Jumps win over branches when both resolve in the same cycle.
                if (jump_valid) begin
                    next_pending = jump_target;
                    next_state   = DELAY;
                end else if (branch_taken) begin
                    next_pending = branch_target;
                    next_state   = DELAY;
                end
            end
            DELAY: begin
                next_pc    = pending;
                next_state = SEQ;
`ifdef MIPS_PC_ALIGN_CHECK_EN
                if (pending[1:0] != 2'b00) begin
                    next_misaligned = 1'b1;
                    next_state      = HALTED;
                end
`endif
            end
            default: ;
        endcase
        // Reaching the halt address stops the core even if a slot was about to start.
        if (state != HALTED && next_pc == HALT_ADDRESS) begin
            next_state = HALTED;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            instr_address <= RESET_VECTOR;
            active        <= 1'b1;
            in_delay_slot <= 1'b0;
            instr_count   <= 32'd0;
            pending       <= 32'd0;
            state         <= SEQ;
`ifdef MIPS_PC_ALIGN_CHECK_EN
            addr_error    <= 1'b0;
`endif
        end else if (adv) begin
            instr_address <= next_pc;
            pending       <= next_pending;
            state         <= next_state;
            in_delay_slot <= (next_state == DELAY);
            active        <= (next_state != HALTED);
            instr_count   <= instr_count + 32'd1;
`ifdef MIPS_PC_ALIGN_CHECK_EN
            addr_error    <= next_misaligned;
`endif
        end
    end

endmodule

// File: tb/tb_mips_pc_sequencer.sv
// Table-driven bench for mips_pc_sequencer plus a hand-written halt-hold sequence.
import mips_pc_pkg::*;

module tb_mips_pc_sequencer;

    typedef struct {
        logic        rst;
        logic        en;
        logic        stl;
        logic        bt;
        logic [31:0] bt_tgt;
        logic        jv;
        logic [31:0] jv_tgt;
        logic [31:0] e_addr;
        logic        e_act;
        logic        e_ds;
        logic [31:0] e_cnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        clk_enable = 1'b0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'd0;
    logic        jump_valid = 1'b0;
    logic [31:0] jump_target = 32'd0;
    logic [31:0] instr_address;
    logic        active;
    logic        in_delay_slot;
    logic [31:0] link_address;
    logic [31:0] instr_count;
    pc_state_t   debug_state;
`ifdef MIPS_PC_ALIGN_CHECK_EN
    logic        addr_error;
`endif

    int vectors_applied = 0;
    int miscompares     = 0;
    vec_t vecs[$];
    logic [31:0] exp_q[$];

    mips_pc_sequencer dut (
        .clk           (clk),
        .reset         (reset),
        .clk_enable    (clk_enable),
        .stall         (stall),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .jump_valid    (jump_valid),
        .jump_target   (jump_target),
        .instr_address (instr_address),
        .active        (active),
        .in_delay_slot (in_delay_slot),
        .link_address  (link_address),
        .instr_count   (instr_count),
`ifdef MIPS_PC_ALIGN_CHECK_EN
        .addr_error    (addr_error),
`endif
        .debug_state   (debug_state)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic en, logic stl, logic bt, logic [31:0] btt,
                                logic jv, logic [31:0] jvt, logic [31:0] addr, logic act,
                                logic ds, logic [31:0] cnt);
        vec_t v;
        v.rst = rst; v.en = en; v.stl = stl; v.bt = bt; v.bt_tgt = btt;
        v.jv = jv; v.jv_tgt = jvt; v.e_addr = addr; v.e_act = act; v.e_ds = ds; v.e_cnt = cnt;
        return v;
    endfunction

    task automatic chk(string nm, logic [31:0] act_v, logic [31:0] exp_v);
        if (act_v !== exp_v) begin
            miscompares++;
            $display("FAIL %s: got %h expected %h", nm, act_v, exp_v);
        end
    endtask

    task automatic drive(logic rst, logic en, logic stl, logic bt, logic [31:0] btt,
                         logic jv, logic [31:0] jvt);
        @(negedge clk);
        reset = rst; clk_enable = en; stall = stl;
        branch_taken = bt; branch_target = btt;
        jump_valid = jv; jump_target = jvt;
        @(posedge clk);
        #1;
    endtask

    task automatic apply(int idx, vec_t v);
        string tag;
        drive(v.rst, v.en, v.stl, v.bt, v.bt_tgt, v.jv, v.jv_tgt);
        vectors_applied++;
        tag = $sformatf("v%0d", idx);
        chk({tag, ".instr_address"}, instr_address, v.e_addr);
        chk({tag, ".active"}, {31'd0, active}, {31'd0, v.e_act});
        chk({tag, ".in_delay_slot"}, {31'd0, in_delay_slot}, {31'd0, v.e_ds});
        chk({tag, ".instr_count"}, instr_count, v.e_cnt);
        chk({tag, ".link_address"}, link_address, v.e_addr + 32'd8);
    endtask

    localparam logic [31:0] RV = 32'hBFC0_0000;
    localparam logic [31:0] Z  = 32'd0;

    initial begin
        logic [31:0] held_cnt;
        // Free-running after reset
        vecs.push_back(mk(1,1,0, 0,Z, 0,Z, RV,          1,0, 0));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC00004,1,0, 1));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC00008,1,0, 2));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC0000C,1,0, 3));
        // Taken branch, then jr to the halt address
        vecs.push_back(mk(1,1,0, 0,Z, 0,Z, RV,          1,0, 0));
        vecs.push_back(mk(0,1,0, 1,32'hBFC0000C, 0,Z, 32'hBFC00004,1,1, 1));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC0000C,1,0, 2));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC00010,1,0, 3));
        vecs.push_back(mk(0,1,0, 0,Z, 1,Z, 32'hBFC00014,1,1, 4));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, Z,           0,0, 5));
        vecs.push_back(mk(0,1,0, 1,32'h40, 1,32'h80, Z, 0,0, 5));
        // Stall held in the delay slot, then clk_enable low
        vecs.push_back(mk(1,1,0, 0,Z, 0,Z, RV,          1,0, 0));
        vecs.push_back(mk(0,1,0, 1,32'hBFC00100, 0,Z, 32'hBFC00004,1,1, 1));
        vecs.push_back(mk(0,1,1, 0,Z, 0,Z, 32'hBFC00004,1,1, 1));
        vecs.push_back(mk(0,1,1, 1,32'hBFC00200, 0,Z, 32'hBFC00004,1,1, 1));
        vecs.push_back(mk(0,1,1, 0,Z, 1,32'hBFC00300, 32'hBFC00004,1,1, 1));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC00100,1,0, 2));
        for (int i = 0; i < 5; i++)
            vecs.push_back(mk(0,0,0, 1,32'hBFC00500, 1,32'hBFC00600, 32'hBFC00100,1,0, 2));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC00104,1,0, 3));
        vecs.push_back(mk(0,1,1, 1,32'hBFC00700, 0,Z, 32'hBFC00104,1,0, 3));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC00108,1,0, 4));
        // Both redirects at once; branch during the slot is ignored
        vecs.push_back(mk(1,1,0, 0,Z, 0,Z, RV,          1,0, 0));
        vecs.push_back(mk(0,1,0, 1,32'hBFC00040, 1,32'hBFC00080, 32'hBFC00004,1,1, 1));
        vecs.push_back(mk(0,1,0, 1,32'hBFC00040, 0,Z, 32'hBFC00080,1,0, 2));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC00084,1,0, 3));
        // Reset in the delay slot drops the pending target
        vecs.push_back(mk(1,1,0, 0,Z, 0,Z, RV,          1,0, 0));
        vecs.push_back(mk(0,1,0, 0,Z, 1,32'hBFC00200, 32'hBFC00004,1,1, 1));
        vecs.push_back(mk(1,0,0, 0,Z, 0,Z, RV,          1,0, 0));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC00004,1,0, 1));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC00008,1,0, 2));
        // Wrap from FFFFFFFC halts, overriding a jump seen there
        vecs.push_back(mk(1,1,0, 0,Z, 0,Z, RV,          1,0, 0));
        vecs.push_back(mk(0,1,0, 0,Z, 1,32'hFFFFFFF8, 32'hBFC00004,1,1, 1));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hFFFFFFF8,1,0, 2));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hFFFFFFFC,1,0, 3));
        vecs.push_back(mk(0,1,0, 0,Z, 1,32'h00001234, Z, 0,0, 4));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, Z,           0,0, 4));
        // Misaligned redirect target
        vecs.push_back(mk(1,1,0, 0,Z, 0,Z, RV,          1,0, 0));
        vecs.push_back(mk(0,1,0, 0,Z, 1,32'hBFC00102, 32'hBFC00004,1,1, 1));
`ifdef MIPS_PC_ALIGN_CHECK_EN
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC00102,0,0, 2));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC00102,0,0, 2));
`else
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC00102,1,0, 2));
        vecs.push_back(mk(0,1,0, 0,Z, 0,Z, 32'hBFC00106,1,0, 3));
`endif

        for (int i = 0; i < vecs.size(); i++) apply(i, vecs[i]);

        // Halt via delay-slot redirect, then hold under random input activity
        drive(1,1,0, 0,Z, 0,Z);
        drive(0,1,0, 0,Z, 1,Z);
        chk("halt_seq.slot_addr", instr_address, 32'hBFC00004);
        chk("halt_seq.slot_ds", {31'd0, in_delay_slot}, 32'd1);
        drive(0,1,0, 0,Z, 0,Z);
        chk("halt_seq.halt_active", {31'd0, active}, 32'd0);
        held_cnt = 32'd2;
        for (int i = 0; i < 10; i++) exp_q.push_back(Z);
        for (int i = 0; i < 10; i++) begin
            logic [31:0] e;
            drive(0, 1'($urandom_range(0,1)), 1'($urandom_range(0,1)),
                  1'($urandom_range(0,1)), $urandom,
                  1'($urandom_range(0,1)), $urandom);
            vectors_applied++;
            e = exp_q.pop_front();
            chk($sformatf("hold%0d.instr_address", i), instr_address, e);
            chk($sformatf("hold%0d.active", i), {31'd0, active}, 32'd0);
            chk($sformatf("hold%0d.in_delay_slot", i), {31'd0, in_delay_slot}, 32'd0);
            chk($sformatf("hold%0d.instr_count", i), instr_count, held_cnt);
        end
`ifdef MIPS_PC_ALIGN_CHECK_EN
        chk("halt_seq.addr_error", {31'd0, addr_error}, 32'd0);
`endif
        drive(1,0,0, 0,Z, 0,Z);
        chk("halt_seq.reset_exit_addr", instr_address, RV);
        chk("halt_seq.reset_exit_active", {31'd0, active}, 32'd1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors_applied, miscompares);
        $finish;
    end

endmodule
